// File: rtl/sr_bank_arbiter_pkg.sv
// Shared types and constants for the SR flop bank arbiter.
package sr_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSettle = 2'd2,
        StCheck  = 2'd3
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer, pick the
// lowest set bit, rotate the one-hot grant back.
module sr_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   gnt_rot;
    logic [2*NUM_REQ-1:0] gnt_dbl;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    // Two's-complement trick isolates the lowest set bit.
    assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    assign grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/sr_bank_arbiter.sv
// Serialises set/clear requests onto a bank of SR flops, one pulse at a time,
// and confirms each result by reading the flop back.
module sr_bank_arbiter
    import sr_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_FF  = 8,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic                     busy,
    output logic [NUM_FF-1:0]        s_vec,
    output logic [NUM_FF-1:0]        r_vec,
    input  logic [NUM_FF-1:0]        q_vec
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic               op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               oor_q, oor_d;
    logic [NUM_REQ-1:0] done_d;
    logic               err_d;
    logic               busy_d;
    logic [NUM_FF-1:0]  s_d, r_d;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   g_win;
    logic               g_op;
    logic [IDX_W-1:0]   g_idx;
    logic               in_range;
    logic               rb;

    sr_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        g_win = '0;
        g_op  = 1'b0;
        g_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                g_win = PTR_W'(k);
                g_op  = req_op[k];
                g_idx = req_idx[k*IDX_W +: IDX_W];
            end
        end
    end

    assign in_range = (32'(g_idx) < NUM_FF);

    always_comb begin
        rb = 1'b0;
        for (int i = 0; i < NUM_FF; i++) begin
            if (idx_q == IDX_W'(i)) rb = q_vec[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        done_d  = '0;
        err_d   = 1'b0;
        s_d     = '0;
        r_d     = '0;

        unique case (state_q)
            StIdle: begin
                // The cycle after done lets the served requester drop req.
                if (done == '0 && req != '0) begin
                    win_d   = g_win;
                    op_d    = g_op;
                    idx_d   = g_idx;
                    oor_d   = ~in_range;
                    // Out-of-range passes through the quiet SETTLE cycle so
                    // done lands two cycles after sampling with no s/r pulse.
                    state_d = in_range ? StDrive : StSettle;
                end
            end
            StDrive:  state_d = StSettle;
            StSettle: state_d = StCheck;
            StCheck: begin
                state_d = StIdle;
                for (int k = 0; k < NUM_REQ; k++) begin
                    done_d[k] = (win_q == PTR_W'(k));
                end
                err_d = oor_q | (rb != op_q);
                ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDrive) begin
            for (int i = 0; i < NUM_FF; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    s_d[i] = (op_d == OP_SET);
                    r_d[i] = (op_d == OP_CLR);
                end
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            s_vec   <= '0;
            r_vec   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            done    <= done_d;
            err     <= err_d;
            busy    <= busy_d;
            s_vec   <= s_d;
            r_vec   <= r_d;
        end
    end

    a_sr_disjoint: assert property (@(posedge clk) (s_vec & r_vec) == '0);
    a_one_line:    assert property (@(posedge clk) $countones(s_vec | r_vec) <= 1);
    a_drive_only:  assert property (@(posedge clk) disable iff (rst)
                                    ((s_vec | r_vec) != '0) |-> (state_q == StDrive));
    a_done_onehot: assert property (@(posedge clk) $countones(done) <= 1);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter with a behavioural SR flop bank.
module tb_sr_bank_arbiter;

    typedef struct {
        logic [7:0] s;
        logic [7:0] r;
        int         cyc;
    } drv_t;

    typedef struct {
        logic [3:0] d;
        logic       e;
        int         cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_op = '0;
    logic [15:0] req_idx = '0;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [7:0]  s_vec;
    logic [7:0]  r_vec;
    logic [7:0]  q_vec;
    logic [7:0]  bank = '0;
    logic [7:0]  stuck = '0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int t0;

    drv_t  drv_q[$];
    done_t done_q[$];
    drv_t  de;
    done_t dn;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        bank <= (bank | s_vec) & ~r_vec;
    end

    // A stuck-at-0 mask lets the bench fake a flop that fails to set.
    assign q_vec = bank & ~stuck;

    sr_bank_arbiter #(
        .NUM_REQ (4),
        .NUM_FF  (8),
        .IDX_W   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_op  (req_op),
        .req_idx (req_idx),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .s_vec   (s_vec),
        .r_vec   (r_vec),
        .q_vec   (q_vec)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_drive(input logic [7:0] s, input logic [7:0] r, input int c);
        drv_q.push_back('{s: s, r: r, cyc: c});
    endtask

    task automatic exp_done(input logic [3:0] d, input logic e, input int c);
        done_q.push_back('{d: d, e: e, cyc: c});
    endtask

    // Monitor: every s/r pulse and every done pulse must match the next expectation.
    initial forever begin
        @(negedge clk);
        check("s_and_r_disjoint", 32'(s_vec & r_vec), 32'd0);
        if ((s_vec | r_vec) != 8'h00) begin
            if (drv_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_drive: got s=%h r=%h, expected none (cycle %0d)",
                         s_vec, r_vec, cyc);
            end else begin
                de = drv_q.pop_front();
                check("drive_s", 32'(s_vec), 32'(de.s));
                check("drive_r", 32'(r_vec), 32'(de.r));
                check("drive_cycle", 32'(cyc), 32'(de.cyc));
            end
        end
        if (done != 4'h0) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%h err=%b, expected none (cycle %0d)",
                         done, err, cyc);
            end else begin
                dn = done_q.pop_front();
                check("done_vec", 32'(done), 32'(dn.d));
                check("done_err", 32'(err), 32'(dn.e));
                check("done_cycle", 32'(cyc), 32'(dn.cyc));
            end
        end
    end

    // Requesters drop req in their done cycle; returns once the block is idle.
    task automatic wait_idle(input int max_cyc);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < max_cyc) begin
            @(negedge clk);
            #1;
            req = req & ~done;
            idle = (req == 4'h0) && !busy && (done == 4'h0);
            n++;
        end
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b req=%h after %0d cycles, expected idle",
                     busy, req, max_cyc);
            req = '0;
        end
    endtask

    task automatic do_reset(input bit rand_in);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            if (rand_in) begin
                req     = 4'($urandom);
                req_op  = 4'($urandom);
                req_idx = 16'($urandom);
            end
            @(negedge clk);
            #1;
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_s", 32'(s_vec), 32'd0);
            check("rst_r", 32'(r_vec), 32'd0);
        end
        req     = '0;
        req_op  = '0;
        req_idx = '0;
        rst     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        do_reset(1'b1);
        wait_idle(20);

        // Set flop 3 from requester 1; later changes to op/idx must be ignored.
        t0 = cyc + 1;
        req = 4'b0010; req_op = 4'b0010; req_idx = 16'h0030;
        exp_drive(8'h08, 8'h00, t0);
        exp_done(4'b0010, 1'b0, t0 + 3);
        @(negedge clk);
        #1;
        req_op = 4'b0000; req_idx = 16'h0000;
        wait_idle(20);
        check("q3_set", 32'(q_vec[3]), 32'd1);

        // Clear flop 3 from requester 1.
        t0 = cyc + 1;
        req = 4'b0010; req_op = 4'b0000; req_idx = 16'h0030;
        exp_drive(8'h00, 8'h08, t0);
        exp_done(4'b0010, 1'b0, t0 + 3);
        wait_idle(20);
        check("q3_clr", 32'(q_vec[3]), 32'd0);

        // Pointer is now 2: requester 3 must win over requester 0.
        t0 = cyc + 1;
        req = 4'b1001; req_op = 4'b0000; req_idx = 16'h6007;
        exp_drive(8'h00, 8'h40, t0);
        exp_done(4'b1000, 1'b0, t0 + 3);
        exp_drive(8'h00, 8'h80, t0 + 5);
        exp_done(4'b0001, 1'b0, t0 + 8);
        wait_idle(40);

        // All four requesters after reset: served 0..3 with 5-cycle spacing.
        do_reset(1'b0);
        wait_idle(20);
        t0 = cyc + 1;
        req = 4'b1111; req_op = 4'b1111; req_idx = 16'h3210;
        for (int k = 0; k < 4; k++) begin
            exp_drive(8'(1 << k), 8'h00, t0 + 5 * k);
            exp_done(4'(1 << k), 1'b0, t0 + 3 + 5 * k);
        end
        wait_idle(60);
        check("q_after_all", 32'(q_vec), 32'h0F);

        // Out-of-range index: error, no s/r activity, done two cycles after sampling.
        t0 = cyc + 1;
        req = 4'b0100; req_op = 4'b0100; req_idx = 16'h0900;
        exp_done(4'b0100, 1'b1, t0 + 2);
        wait_idle(20);
        check("q_after_oor", 32'(q_vec), 32'h0F);

        // Flop 5 stuck at 0: the set pulse is issued but readback flags an error.
        stuck = 8'h20;
        t0 = cyc + 1;
        req = 4'b0001; req_op = 4'b0001; req_idx = 16'h0005;
        exp_drive(8'h20, 8'h00, t0);
        exp_done(4'b0001, 1'b1, t0 + 3);
        wait_idle(20);
        stuck = 8'h00;

        // Reset while DRIVE is on the bus: outputs clear at the next edge, no done.
        t0 = cyc + 1;
        req = 4'b0010; req_op = 4'b0010; req_idx = 16'h0040;
        exp_drive(8'h10, 8'h00, t0);
        @(negedge clk);
        #1;
        check("in_drive_before_rst", 32'(s_vec), 32'h10);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        #1;
        check("midrst_s", 32'(s_vec), 32'd0);
        check("midrst_r", 32'(r_vec), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;

        // Pointer must be back at 0: requester 0 before requester 3.
        t0 = cyc + 1;
        req = 4'b1001; req_op = 4'b0000; req_idx = 16'h7006;
        exp_drive(8'h00, 8'h40, t0);
        exp_done(4'b0001, 1'b0, t0 + 3);
        exp_drive(8'h00, 8'h80, t0 + 5);
        exp_done(4'b1000, 1'b0, t0 + 8);
        wait_idle(40);

        repeat (3) @(negedge clk);
        #1;
        check("drive_queue_empty", 32'(drv_q.size()), 32'd0);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
